// File: rtl/frame_arb_pkg.sv
// Shared types and widths for the frame arbiter and its round-robin picker.
package frame_arb_pkg;

    localparam int BYTE_W      = 8;
    localparam int FRAME_CNT_W = 16;
    localparam int LEN_CNT_W   = 16;
    localparam int GAP_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, one-hot.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_start,
    output logic [N-1:0]     o_pick
);

    // Walk offsets from the far end so the nearest request to i_start wins last.
    always_comb begin
        o_pick = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (i_req[(int'(i_start) + off) % N]) begin
                o_pick = '0;
                o_pick[(int'(i_start) + off) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_arbiter.sv
// Round-robin byte-stream frame arbiter with inter-frame gap and length abort.
// state | meaning: IDLE arbitrate | XFER forward owner bytes | GAP forced idle | DRAIN discard to last
module frame_arbiter
    import frame_arb_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int IFG     = 2,
    parameter int MAX_LEN = 1518
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         src_valid,
    input  logic [BYTE_W*N_SRC-1:0]  src_data,
    input  logic [N_SRC-1:0]         src_last,
    output logic [N_SRC-1:0]         src_ready,
    output logic [N_SRC-1:0]         grant,
    output logic [BYTE_W-1:0]        rxd,
    output logic                     rx_dv,
    output logic                     len_err,
    output logic [FRAME_CNT_W-1:0]   frame_cnt
);

    localparam int                   PTR_W    = ptr_width(N_SRC);
    localparam logic [LEN_CNT_W-1:0] LEN_MAX  = LEN_CNT_W'(MAX_LEN);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((IFG > 0) ? IFG - 1 : 0);
    localparam arb_state_t           END_ST   = (IFG > 0) ? ST_GAP : ST_IDLE;

    arb_state_t             r_state,  w_state_nxt;
    logic [N_SRC-1:0]       r_grant,  w_grant_nxt;
    logic [PTR_W-1:0]       r_ptr,    w_ptr_nxt;
    logic [LEN_CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [GAP_CNT_W-1:0]   r_gap,    w_gap_nxt;
    logic [BYTE_W-1:0]      r_rxd,    w_rxd_nxt;
    logic                   r_dv,     w_dv_nxt;
    logic                   r_lerr,   w_lerr_nxt;
    logic [FRAME_CNT_W-1:0] r_fcnt,   w_fcnt_nxt;

    logic [N_SRC-1:0]  w_pick;
    logic [PTR_W-1:0]  w_ptr_after;
    logic [BYTE_W-1:0] w_byte;
    logic              w_last;
    logic              w_busy;
    logic              w_acc;

    rr_pick #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req   (src_valid),
        .i_start (r_ptr),
        .o_pick  (w_pick)
    );

    always_comb begin
        w_byte      = '0;
        w_last      = 1'b0;
        w_ptr_after = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant[i]) begin
                w_byte = src_data[BYTE_W*i +: BYTE_W];
                w_last = src_last[i];
            end
            if (w_pick[i]) begin
                w_ptr_after = PTR_W'((i + 1) % N_SRC);
            end
        end
    end

    assign w_busy    = (r_state == ST_XFER) || (r_state == ST_DRAIN);
    assign src_ready = w_busy ? r_grant : '0;
    assign w_acc     = |(src_valid & src_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_rxd_nxt   = r_rxd;
        w_dv_nxt    = 1'b0;
        w_lerr_nxt  = 1'b0;
        w_fcnt_nxt  = r_fcnt;
        unique case (r_state)
            ST_IDLE: begin
                if (|src_valid) begin
                    w_grant_nxt = w_pick;
                    w_ptr_nxt   = w_ptr_after;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_acc) begin
                    // r_cnt holds bytes already accepted; this one would exceed the limit.
                    if (r_cnt >= LEN_MAX) begin
                        w_lerr_nxt = 1'b1;
                        if (w_last) begin
                            w_grant_nxt = '0;
                            w_gap_nxt   = GAP_LOAD;
                            w_state_nxt = END_ST;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end else begin
                        w_rxd_nxt = w_byte;
                        w_dv_nxt  = 1'b1;
                        w_cnt_nxt = r_cnt + LEN_CNT_W'(1);
                        if (w_last) begin
                            w_fcnt_nxt  = r_fcnt + FRAME_CNT_W'(1);
                            w_grant_nxt = '0;
                            w_gap_nxt   = GAP_LOAD;
                            w_state_nxt = END_ST;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (w_acc && w_last) begin
                    w_grant_nxt = '0;
                    w_gap_nxt   = GAP_LOAD;
                    w_state_nxt = END_ST;
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - GAP_CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_rxd   <= '0;
            r_dv    <= 1'b0;
            r_lerr  <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_rxd   <= w_rxd_nxt;
            r_dv    <= w_dv_nxt;
            r_lerr  <= w_lerr_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    assign grant     = r_grant;
    assign rxd       = r_rxd;
    assign rx_dv     = r_dv;
    assign len_err   = r_lerr;
    assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_frame_arbiter.sv
// Bench for frame_arbiter: directed scenarios plus random frames against a frame-level reference model.
module tb_frame_arbiter;

    localparam int N       = 4;
    localparam int IFG     = 2;
    localparam int MAX_LEN = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   src_valid = '0;
    logic [8*N-1:0] src_data = '0;
    logic [N-1:0]   src_last = '0;
    logic [N-1:0]   src_ready;
    logic [N-1:0]   grant;
    logic [7:0]     rxd;
    logic           rx_dv;
    logic           len_err;
    logic [15:0]    frame_cnt;

    always #5 clk = ~clk;

    frame_arbiter #(
        .N_SRC   (N),
        .IFG     (IFG),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .grant     (grant),
        .rxd       (rxd),
        .rx_dv     (rx_dv),
        .len_err   (len_err),
        .frame_cnt (frame_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pending traffic per source: byte stream and frame lengths.
    logic [7:0] bq[N][$];
    int         lq[N][$];
    int         pos[N];
    int         stall_at[N];
    int         stall_n[N];
    int         thr;

    // Reference model: expected outputs for the current cycle and the next one.
    int          cyc;
    int          cur_g, nxt_g;
    logic        cur_dv, nxt_dv, cur_lerr, nxt_lerr;
    logic [7:0]  cur_rxd, nxt_rxd;
    logic [15:0] cur_fcnt, nxt_fcnt;
    int          in_cnt;
    int          rr_ptr;
    int          free_at;

    logic [N-1:0]   prev_grant;
    logic [N-1:0]   obs_order[$];
    int             lerr_seen;
    int             dv_seen;
    int             gcyc_seen;
    logic [N-1:0]   dv_v, dl_v;
    logic [8*N-1:0] dd_v;

    function automatic logic [N-1:0] oh(input int g);
        return (g < 0) ? '0 : N'(1 << g);
    endfunction

    function automatic bit busy();
        bit b = (cur_g >= 0);
        for (int s = 0; s < N; s++) if (lq[s].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cur_g    = -1;
        cur_dv   = 1'b0;
        cur_lerr = 1'b0;
        cur_rxd  = 8'h00;
        cur_fcnt = 16'h0000;
        in_cnt   = 0;
        rr_ptr   = 0;
        free_at  = cyc;
        prev_grant = '0;
    endtask

    task automatic enq(input int s, input int len, input logic [7:0] b0);
        for (int i = 0; i < len; i++) bq[s].push_back(8'(b0 + 8'(i) * 8'h11));
        lq[s].push_back(len);
    endtask

    task automatic clear_logs();
        obs_order.delete();
        lerr_seen = 0;
        dv_seen   = 0;
        gcyc_seen = 0;
    endtask

    task automatic step();
        int     s;
        bit     found;
        logic [7:0] b;
        @(negedge clk);
        check("grant", 32'(grant), 32'(oh(cur_g)));
        check("rx_dv", 32'(rx_dv), 32'(cur_dv));
        if (cur_dv) check("rxd", 32'(rxd), 32'(cur_rxd));
        check("len_err", 32'(len_err), 32'(cur_lerr));
        check("frame_cnt", 32'(frame_cnt), 32'(cur_fcnt));
        if (grant !== prev_grant && grant !== '0) obs_order.push_back(grant);
        prev_grant = grant;
        if (len_err === 1'b1) lerr_seen++;
        if (rx_dv === 1'b1) dv_seen++;
        if (grant !== '0) gcyc_seen++;

        for (int k = 0; k < N; k++) begin
            if (lq[k].size() > 0) begin
                if (stall_n[k] > 0 && pos[k] == stall_at[k]) begin
                    dv_v[k] = 1'b0;
                    stall_n[k]--;
                end else begin
                    dv_v[k] = ($urandom_range(99) < thr);
                end
                dd_v[8*k +: 8] = bq[k][0];
                dl_v[k] = (pos[k] == lq[k][0] - 1);
            end else begin
                dv_v[k] = 1'b0;
                dd_v[8*k +: 8] = 8'($urandom);
                dl_v[k] = 1'($urandom);
            end
        end
        src_valid = dv_v;
        src_data  = dd_v;
        src_last  = dl_v;
        #1;
        check("src_ready", 32'(src_ready), 32'(oh(cur_g)));

        nxt_g    = cur_g;
        nxt_dv   = 1'b0;
        nxt_lerr = 1'b0;
        nxt_rxd  = cur_rxd;
        nxt_fcnt = cur_fcnt;
        if (cur_g >= 0) begin
            if (dv_v[cur_g]) begin
                s = cur_g;
                in_cnt++;
                b = bq[s].pop_front();
                if (in_cnt <= MAX_LEN) begin
                    nxt_dv  = 1'b1;
                    nxt_rxd = b;
                end else if (in_cnt == MAX_LEN + 1) begin
                    nxt_lerr = 1'b1;
                end
                pos[s]++;
                if (dl_v[s]) begin
                    if (in_cnt <= MAX_LEN) nxt_fcnt = cur_fcnt + 16'd1;
                    nxt_g   = -1;
                    free_at = cyc + IFG + 1;
                    pos[s]  = 0;
                    void'(lq[s].pop_front());
                end
            end
        end else if (cyc >= free_at && dv_v != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && dv_v[(rr_ptr + k) % N]) begin
                    nxt_g = (rr_ptr + k) % N;
                    found = 1'b1;
                end
            end
            rr_ptr = (nxt_g + 1) % N;
            in_cnt = 0;
        end
        cyc++;
        cur_g    = nxt_g;
        cur_dv   = nxt_dv;
        cur_lerr = nxt_lerr;
        cur_rxd  = nxt_rxd;
        cur_fcnt = nxt_fcnt;
    endtask

    task automatic run_idle(input int budget);
        int k = 0;
        while (busy() && k < budget) begin
            step();
            k++;
        end
        check("run_timeout", 32'(busy()), 32'd0);
        repeat (IFG + 2) step();
    endtask

    // Asserts reset mid-cycle so the asynchronous clear is visible before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd0);
        check("rst_rxd", 32'(rxd), 32'd0);
        check("rst_rx_dv", 32'(rx_dv), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        for (int s = 0; s < N; s++) begin
            bq[s].delete();
            lq[s].delete();
            pos[s]      = 0;
            stall_at[s] = -1;
            stall_n[s]  = 0;
        end
        src_valid = '0;
        src_last  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_logs();
    endtask

    initial begin
        logic [N-1:0] exp_ord[5];
        int k;
        cyc = 0;
        thr = 100;
        model_reset();
        #2;
        do_reset();

        // Single 3-byte frame from src0.
        enq(0, 3, 8'h11);
        run_idle(50);
        check("s23_frame_cnt", 32'(frame_cnt), 32'd1);
        check("s23_dv_cycles", 32'(dv_seen), 32'd3);
        check("s23_owner", 32'(obs_order[0]), 32'h1);

        // All four sources compete with 2-byte frames; src0 has a second frame.
        do_reset();
        enq(0, 2, 8'h01);
        enq(1, 2, 8'h21);
        enq(2, 2, 8'h41);
        enq(3, 2, 8'h61);
        enq(0, 2, 8'h81);
        run_idle(100);
        exp_ord = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        check("s24_n_grants", 32'(obs_order.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_order.size(); i++) check("s24_order", 32'(obs_order[i]), 32'(exp_ord[i]));
        check("s24_frame_cnt", 32'(frame_cnt), 32'd5);

        // Src1 stalls 3 cycles after its second byte; grant must persist.
        do_reset();
        stall_at[1] = 2;
        stall_n[1]  = 3;
        enq(1, 4, 8'h31);
        run_idle(50);
        check("s25_grant_cycles", 32'(gcyc_seen), 32'd7);
        check("s25_dv_cycles", 32'(dv_seen), 32'd4);
        check("s25_frame_cnt", 32'(frame_cnt), 32'd1);

        // Oversize frame from src2: 6 bytes against MAX_LEN=4.
        do_reset();
        enq(2, 6, 8'h10);
        run_idle(50);
        check("s26_len_err_pulses", 32'(lerr_seen), 32'd1);
        check("s26_dv_cycles", 32'(dv_seen), 32'd4);
        check("s26_frame_cnt", 32'(frame_cnt), 32'd0);

        // Exactly MAX_LEN bytes is legal.
        clear_logs();
        enq(2, 4, 8'h50);
        run_idle(50);
        check("s27_len_err_pulses", 32'(lerr_seen), 32'd0);
        check("s27_dv_cycles", 32'(dv_seen), 32'd4);
        check("s27_frame_cnt", 32'(frame_cnt), 32'd1);

        // Reset while byte 2 of a src1 frame is on the bus, then src3 and src0 request.
        do_reset();
        enq(1, 5, 8'h70);
        k = 0;
        while (pos[1] < 1 && k < 20) begin
            step();
            k++;
        end
        check("s28_reach_byte2", 32'(pos[1]), 32'd1);
        step();
        do_reset();
        enq(3, 2, 8'hA0);
        enq(0, 2, 8'hC0);
        run_idle(60);
        check("s28_first_owner", 32'(obs_order.size() > 0 ? obs_order[0] : '0), 32'h1);
        check("s28_frame_cnt", 32'(frame_cnt), 32'd2);
        check("s28_len_err_pulses", 32'(lerr_seen), 32'd0);

        // Random frames, throttling and source mixes checked cycle by cycle.
        do_reset();
        for (int batch = 0; batch < 20; batch++) begin
            int nfr;
            thr = $urandom_range(40, 100);
            nfr = $urandom_range(1, 4);
            for (int f = 0; f < nfr; f++) begin
                int r;
                r = $urandom_range(0, 5);
                enq($urandom_range(0, N - 1), (r < 4) ? r + 1 : MAX_LEN + r - 2, 8'($urandom));
            end
            run_idle(800);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
